// File: rtl/hazard_forward_unit_if.sv
// Decode <-> hazard unit bundle: source requests, EX-slot producer info,
// per-stage results and the resolved operands/stall returned to decode.
interface hazard_forward_unit_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       de_rs_addr;
    logic [5:0]       de_rt_addr;
    logic [31:0]      rf_rs_data;
    logic [31:0]      rf_rt_data;
    logic             de_reg_en;
    logic [5:0]       de_reg_waddr;
    logic             de_mem_read;
    logic [31:0]      ex_result;
    logic [31:0]      mem_result;
    logic [31:0]      wb_result;
    logic [31:0]      de_rs_data;
    logic [31:0]      de_rt_data;
    logic             stall;
    logic [CNT_W-1:0] stall_cycles;

    // pipeline side: drives requests and stage results
    modport master (
        output de_rs_addr, de_rt_addr, rf_rs_data, rf_rt_data,
               de_reg_en, de_reg_waddr, de_mem_read,
               ex_result, mem_result, wb_result,
        input  de_rs_data, de_rt_data, stall, stall_cycles
    );

    // hazard unit side
    modport slave (
        input  de_rs_addr, de_rt_addr, rf_rs_data, rf_rt_data,
               de_reg_en, de_reg_waddr, de_mem_read,
               ex_result, mem_result, wb_result,
        output de_rs_data, de_rt_data, stall, stall_cycles
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Operand hazard / forwarding unit for the 5-stage MIPS pipeline.
// Tracks register writers in EX (live inputs), MEM and WB (registered copies),
// including HI (6'b100001) and LO (6'b100000).
// Build option: define HAZARD_FORWARD_EN to enable the bypass muxes; without it
// every in-flight match stalls and operands always come from the regfile.

// Resolves one source operand against the three producer slots.
// Slot index 0 = EX, 1 = MEM, 2 = WB; lower index is younger and wins.
module hfu_src_resolve (
    input  logic [5:0]       src,
    input  logic [31:0]      rf_data,
    input  logic [2:0]       slot_v,
    input  logic [2:0][5:0]  slot_addr,
    input  logic [1:0]       slot_ld,
    input  logic [2:0][31:0] slot_res,
    output logic [31:0]      data,
    output logic             stall
);
    logic [2:0] hit;

    // a slot matches when valid, same address, and source is not r0
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            hit[k] = slot_v[k] && (slot_addr[k] == src) && (src != 6'd0);
        end
    end

`ifdef HAZARD_FORWARD_EN
    // youngest producer wins; a load in EX or MEM has no data yet, so stall
    always_comb begin
        data  = rf_data;
        stall = 1'b0;
        if (hit[0]) begin
            data  = slot_res[0];
            stall = slot_ld[0];
        end else if (hit[1]) begin
            data  = slot_res[1];
            stall = slot_ld[1];
        end else if (hit[2]) begin
            data  = slot_res[2];
        end
    end
`else
    // no bypass: wait until the producer has left WB and the regfile holds it
    logic unused_fwd;
    assign unused_fwd = ^{slot_res, slot_ld};
    assign data       = rf_data;
    assign stall      = |hit;
`endif
endmodule

module hazard_forward_unit #(
    parameter int CNT_W = 16
) (
    input logic                 clk,
    input logic                 resetn,
    hazard_forward_unit_if.slave hz
);
    localparam int NUM_SRC = 2;

    // producer tracking: vld_pipe[1] = MEM, vld_pipe[2] = WB
    logic [2:1]         vld_pipe;
    logic [5:0]         mem_addr;
    logic [5:0]         wb_addr;
    logic               mem_ld;

    logic [2:0]         slot_v;
    logic [2:0][5:0]    slot_addr;
    logic [1:0]         slot_ld;
    logic [2:0][31:0]   slot_res;

    logic [NUM_SRC-1:0][5:0]  src_addr;
    logic [NUM_SRC-1:0][31:0] src_rf;
    logic [NUM_SRC-1:0][31:0] src_data;
    logic [NUM_SRC-1:0]       src_stall;

    logic [CNT_W-1:0]   cnt;

    assign slot_v    = {vld_pipe, hz.de_reg_en};
    assign slot_addr = {wb_addr, mem_addr, hz.de_reg_waddr};
    assign slot_ld   = {mem_ld, hz.de_mem_read};
    assign slot_res  = {hz.wb_result, hz.mem_result, hz.ex_result};

    assign src_addr  = {hz.de_rt_addr, hz.de_rs_addr};
    assign src_rf    = {hz.rf_rt_data, hz.rf_rs_data};

    // back end never stalls: EX -> MEM -> WB shift every cycle, bubbles enter as en=0
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_pipe <= '0;
            mem_ld   <= 1'b0;
            mem_addr <= '0;
            wb_addr  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], hz.de_reg_en};
            mem_ld   <= hz.de_mem_read;
            mem_addr <= hz.de_reg_waddr;
            wb_addr  <= mem_addr;
        end
    end

    // rs and rt are resolved independently
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hfu_src_resolve u_res (
            .src       (src_addr[i]),
            .rf_data   (src_rf[i]),
            .slot_v    (slot_v),
            .slot_addr (slot_addr),
            .slot_ld   (slot_ld),
            .slot_res  (slot_res),
            .data      (src_data[i]),
            .stall     (src_stall[i])
        );
    end

    assign hz.de_rs_data = src_data[0];
    assign hz.de_rt_data = src_data[1];
    assign hz.stall      = |src_stall;

    // saturating count of stalled cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (hz.stall && !(&cnt)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hz.stall_cycles = cnt;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: a slot-history model checked every cycle,
// plus directed literal expectations for both builds of HAZARD_FORWARD_EN.
module tb_hazard_forward_unit;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    hazard_forward_unit_if #(.CNT_W(CNT_W)) hz ();

    hazard_forward_unit #(.CNT_W(CNT_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .hz     (hz)
    );

    typedef struct {
        bit         v;
        bit         ld;
        logic [5:0] a;
    } slot_t;

    slot_t   m_mem = '{0, 0, 6'd0};
    slot_t   m_wb  = '{0, 0, 6'd0};
    int      m_cnt = 0;
    int      checks = 0;
    int      failures = 0;

    // what decode must see for one source: scan producers youngest-first
    function automatic void resolve(input logic [5:0] src, input logic [31:0] rf,
                                    output logic [31:0] d, output bit st);
        slot_t       s [3];
        logic [31:0] r [3];
        s[0] = '{hz.de_reg_en, hz.de_mem_read, hz.de_reg_waddr};
        s[1] = m_mem;
        s[2] = m_wb;
        r[0] = hz.ex_result;
        r[1] = hz.mem_result;
        r[2] = hz.wb_result;
        d  = rf;
        st = 0;
        for (int k = 0; k < 3; k++) begin
            if (s[k].v && src != 6'd0 && s[k].a == src) begin
`ifdef HAZARD_FORWARD_EN
                d  = r[k];
                st = (k < 2) && s[k].ld;
`else
                st = 1;
`endif
                return;
            end
        end
    endfunction

    function automatic bit model_stall();
        logic [31:0] d;
        bit a, b;
        resolve(hz.de_rs_addr, hz.rf_rs_data, d, a);
        resolve(hz.de_rt_addr, hz.rf_rt_data, d, b);
        return a | b;
    endfunction

    // model state: shift producers, count stalls
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_mem <= '{0, 0, 6'd0};
            m_wb  <= '{0, 0, 6'd0};
            m_cnt <= 0;
        end else begin
            if (model_stall() && m_cnt < 65535) m_cnt <= m_cnt + 1;
            m_mem <= '{hz.de_reg_en, hz.de_mem_read, hz.de_reg_waddr};
            m_wb  <= m_mem;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // every-cycle comparison against the model
    always @(negedge clk) begin
        logic [31:0] ers, ert;
        bit          srs, srt;
        resolve(hz.de_rs_addr, hz.rf_rs_data, ers, srs);
        resolve(hz.de_rt_addr, hz.rf_rt_data, ert, srt);
        chk("model_rs_data", hz.de_rs_data, ers);
        chk("model_rt_data", hz.de_rt_data, ert);
        chk("model_stall", {31'd0, hz.stall}, {31'd0, srs | srt});
        chk("model_stall_cycles", {16'd0, hz.stall_cycles}, m_cnt[31:0]);
    end

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input logic en, input logic [5:0] wa, input logic ld,
                       input logic [5:0] rs, input logic [5:0] rt);
        hz.de_reg_en    = en;
        hz.de_reg_waddr = wa;
        hz.de_mem_read  = ld;
        hz.de_rs_addr   = rs;
        hz.de_rt_addr   = rt;
    endtask

    // one reset cycle, released 2 time units after an edge
    task automatic rst_pulse();
        drv(0, 6'd0, 0, 6'd0, 6'd0);
        resetn = 1'b0;
        nxt();
        resetn = 1'b1;
    endtask

    initial begin
        hz.rf_rs_data = 32'hAAAA;
        hz.rf_rt_data = 32'hBBBB;
        hz.ex_result  = 32'h1111;
        hz.mem_result = 32'h2222;
        hz.wb_result  = 32'h3333;
        drv(0, 6'd0, 0, 6'd0, 6'd0);
        #2;

        // 1: reset with a live EX hazard on r5
        drv(1, 6'd5, 0, 6'd5, 6'd0);
        @(negedge clk);
        chk("rst_cnt", {16'd0, hz.stall_cycles}, 32'd0);
`ifdef HAZARD_FORWARD_EN
        chk("rst_ex_fwd", hz.de_rs_data, 32'h1111);
        chk("rst_stall", {31'd0, hz.stall}, 32'd0);
`else
        chk("rst_stall", {31'd0, hz.stall}, 32'd1);
        chk("rst_rf", hz.de_rs_data, 32'hAAAA);
`endif
        nxt();
        resetn = 1'b1;
        @(negedge clk);
`ifdef HAZARD_FORWARD_EN
        chk("rel_ex_fwd", hz.de_rs_data, 32'h1111);
`else
        chk("rel_stall", {31'd0, hz.stall}, 32'd1);
`endif
        nxt();

        // 2 / 6: addu r5 then addu r6,r5,r5
        rst_pulse();
        hz.ex_result = 32'h1234;
        drv(1, 6'd5, 0, 6'd5, 6'd5);
        @(negedge clk);
`ifdef HAZARD_FORWARD_EN
        chk("alu_rs", hz.de_rs_data, 32'h1234);
        chk("alu_rt", hz.de_rt_data, 32'h1234);
        chk("alu_stall", {31'd0, hz.stall}, 32'd0);
`else
        chk("nf_stall0", {31'd0, hz.stall}, 32'd1);
        nxt();
        drv(0, 6'd0, 0, 6'd5, 6'd5);
        @(negedge clk);
        chk("nf_stall1", {31'd0, hz.stall}, 32'd1);
        nxt();
        @(negedge clk);
        chk("nf_stall2", {31'd0, hz.stall}, 32'd1);
        nxt();
        @(negedge clk);
        chk("nf_free", {31'd0, hz.stall}, 32'd0);
        chk("nf_rf", hz.de_rs_data, 32'hAAAA);
        chk("nf_cnt", {16'd0, hz.stall_cycles}, 32'd3);
`endif
        nxt();

        // 3: lw r7 then addu r8,r7,r0
        rst_pulse();
        hz.wb_result = 32'hCAFE;
        drv(1, 6'd7, 1, 6'd7, 6'd0);
        @(negedge clk);
        chk("lu_stall0", {31'd0, hz.stall}, 32'd1);
        nxt();
        drv(0, 6'd0, 0, 6'd7, 6'd0);
        @(negedge clk);
        chk("lu_stall1", {31'd0, hz.stall}, 32'd1);
        nxt();
        @(negedge clk);
`ifdef HAZARD_FORWARD_EN
        chk("lu_free", {31'd0, hz.stall}, 32'd0);
        chk("lu_wb", hz.de_rs_data, 32'hCAFE);
        chk("lu_rt_rf", hz.de_rt_data, 32'hBBBB);
        chk("lu_cnt", {16'd0, hz.stall_cycles}, 32'd2);
`else
        chk("lu_stall2", {31'd0, hz.stall}, 32'd1);
        nxt();
        @(negedge clk);
        chk("lu_free", {31'd0, hz.stall}, 32'd0);
        chk("lu_cnt", {16'd0, hz.stall_cycles}, 32'd3);
`endif
        nxt();

        // 4: r9 in EX, MEM and WB
        rst_pulse();
        hz.ex_result = 32'd1;
        hz.mem_result = 32'd2;
        hz.wb_result = 32'd3;
        drv(1, 6'd9, 0, 6'd0, 6'd0);
        nxt();
        nxt();
        drv(1, 6'd9, 0, 6'd9, 6'd0);
        @(negedge clk);
`ifdef HAZARD_FORWARD_EN
        chk("prio_ex", hz.de_rs_data, 32'd1);
`else
        chk("prio_stall", {31'd0, hz.stall}, 32'd1);
`endif
        nxt();
        drv(0, 6'd0, 0, 6'd9, 6'd0);
        @(negedge clk);
`ifdef HAZARD_FORWARD_EN
        chk("prio_mem", hz.de_rs_data, 32'd2);
`else
        chk("prio_rf", hz.de_rs_data, 32'hAAAA);
`endif
        nxt();

        // 5: r0 never matches; HI forwarded from EX
        rst_pulse();
        hz.rf_rs_data = 32'h55;
        drv(1, 6'd0, 0, 6'd0, 6'd0);
        @(negedge clk);
        chk("zero_rf", hz.de_rs_data, 32'h55);
        chk("zero_stall", {31'd0, hz.stall}, 32'd0);
        nxt();
        rst_pulse();
        hz.ex_result = 32'hBEEF;
        drv(1, 6'b100001, 0, 6'b100001, 6'd0);
        @(negedge clk);
`ifdef HAZARD_FORWARD_EN
        chk("hi_fwd", hz.de_rs_data, 32'hBEEF);
`else
        chk("hi_stall", {31'd0, hz.stall}, 32'd1);
`endif
        nxt();

        // saturation: a load in EX feeding rs holds stall high in both builds
        rst_pulse();
        drv(1, 6'd10, 1, 6'd10, 6'd0);
        for (int i = 0; i < 65540; i++) nxt();
        @(negedge clk);
        chk("sat_cnt", {16'd0, hz.stall_cycles}, 32'hFFFF);
        chk("sat_stall", {31'd0, hz.stall}, 32'd1);

        // reset mid-stall drops all producers
        drv(0, 6'd0, 0, 6'd10, 6'd0);
        resetn = 1'b0;
        #1;
        chk("midrst_stall", {31'd0, hz.stall}, 32'd0);
        chk("midrst_cnt", {16'd0, hz.stall_cycles}, 32'd0);
        nxt();
        resetn = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", {31'd0, hz.stall}, 32'd0);
        nxt();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
